fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
// - Read-side companion of the team's byte FIFO. Pops FIFO entries and packs PACK entries into one wide word.
// - Presents each word to a downstream consumer on a valid/ready stream.
// - flush request drains the FIFO and emits the final partial word with a lane mask and last flag.
// - Sits between the FIFO read port and the wide datapath (e.g. activation/weight loaders).
// PARAMETERS
// - FIFO_WIDTH  8                     width of one FIFO entry (lane)
// - PACK        4                     lanes per output word, >=2
// - IDX_W       $clog2(PACK)          lane index width
// PORTS
// - clk           in   1               clock, all logic on posedge
// - rst           in   1               reset, synchronous, active-high
// - fifo_empty    in   1               FIFO empty indication
// - fifo_data     in   FIFO_WIDTH      FIFO head entry; show-ahead, valid whenever fifo_empty=0
// - fifo_read_en  out  1               pop strobe to the FIFO read_en
// - flush         in   1               1-cycle request: drain and emit partial word
// - out_valid     out  1               output word valid
// - out_ready     in   1               consumer accepts the word
// - out_data      out  PACK*FIFO_WIDTH packed word; lane 0 = bits [FIFO_WIDTH-1:0] = first popped
// - out_keep      out  PACK            bit i=1 -> lane i holds data
// - out_last      out  1               word closes a flush
// - flush_done    out  1               1-cycle pulse, flush complete
// - busy          out  1               state==HOLD | idx!=0 | flush_pend
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - State=FILL, idx=0, flush_pend=0.
//   - out_data, out_keep, out_last, out_valid, flush_done all 0.
//   - Partial data is discarded.
//   - fifo_read_en=0 in every cycle rst=1.
// - fifo_read_en is combinational: (state==FILL) & ~fifo_empty & ~rst.
//   - Never asserted when fifo_empty=1. The FIFO has no underflow guard.
// - State FILL, on a pop:
//   - out_data lane[idx] <= fifo_data, out_keep[idx] <= 1.
//   - If idx==PACK-1: idx<=0, go HOLD with out_last=0.
//   - Otherwise idx<=idx+1.
// - flush input:
//   - Sets flush_pend in any state.
//   - A flush while flush_pend=1 is absorbed (no second completion).
// - State FILL with flush_pend=1 and fifo_empty=1:
//   - idx!=0: go HOLD with out_last=1, out_keep as filled; unfilled lanes stay 0.
//   - idx==0: clear flush_pend; flush_done=1 next cycle; no word is emitted.
// - State HOLD:
//   - out_valid=1. out_data, out_keep and out_last are stable until accepted.
//   - No pops in HOLD.
//   - On out_valid & out_ready: go FILL and clear out_data, out_keep, out_last.
//   - If that word had out_last=1, also clear flush_pend; flush_done=1 in the next cycle.
// - out_last appears only on partial (flush-closed) words.
//   - A flush that ends on a full-word boundary completes via the idx==0 path.
// - Throughput: one full word per PACK+1 cycles with no stalls (PACK pops + 1 HOLD cycle).
// - flush arriving in the same cycle as a pop: the pop proceeds, flush_pend sets; evaluated from the next cycle.
// - No internal overflow: pops stop in HOLD, so upstream backpressure comes through FIFO fullness only.
// TESTING
// - Push 0x11..0x88, out_ready=1 -> words 0x44332211 then 0x88776655, keep=4'hF, last=0, no flush_done.
// - 8 bytes in FIFO, out_ready=0 for 10 cycles:
//   - first word held stable and fifo_read_en=0 during HOLD;
//   - ready=1 -> second word follows after 4 pops.
// - Push 0xA1,0xA2 then pulse flush -> word 0x0000A2A1, keep=4'h3, last=1; flush_done 1 cycle after accept.
// - FIFO empty, idx=0, pulse flush -> out_valid never rises; flush_done pulses on the second cycle after flush.
// - fifo_empty=1 throughout with random flush/out_ready -> fifo_read_en never 1; out_valid never 1.
// - 3 bytes popped, rst=1 for one cycle -> all outputs 0; next 4 bytes 0x01..0x04 -> clean word 0x04030201.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// Signal bundle between the byte FIFO read port, the read-side packer and the wide-word consumer.
// The master modport is the packer's view; the slave modport is the surrounding FIFO/consumer view.
interface fifo_rd_packer_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int PACK       = 4
);
    logic                         fifo_empty;
    logic [FIFO_WIDTH-1:0]        fifo_data;
    logic                         fifo_read_en;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    logic [PACK*FIFO_WIDTH-1:0]   out_data;
    logic [PACK-1:0]              out_keep;
    logic                         out_last;
    logic                         flush_done;
    logic                         busy;

    modport master (
        input  fifo_empty, fifo_data, flush, out_ready,
        output fifo_read_en, out_valid, out_data, out_keep, out_last, flush_done, busy
    );

    modport slave (
        output fifo_empty, fifo_data, flush, out_ready,
        input  fifo_read_en, out_valid, out_data, out_keep, out_last, flush_done, busy
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops a show-ahead byte FIFO and packs PACK entries into one wide word on a valid/ready stream;
// a flush drains the FIFO and closes any partial word with a lane mask and a last flag.
module fifo_rd_packer #(
    parameter int FIFO_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int IDX_W      = $clog2(PACK)
) (
    input logic              clk,
    input logic              rst,
    fifo_rd_packer_if.master bus
);
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

    state_t                     state, state_nx;
    logic [IDX_W-1:0]           idx, idx_nx;
    logic [PACK*FIFO_WIDTH-1:0] data_q, data_nx;
    logic [PACK-1:0]            keep_q, keep_nx;
    logic                       last_q, last_nx;
    logic                       pend, pend_nx;
    logic                       done_q, done_nx;
    logic                       pop;

    assign pop = (state == FILL) & ~bus.fifo_empty & ~rst;

    // NOTE: every variable is given a default before the case so no path leaves it unassigned,
    // which is what keeps always_comb free of inferred latches.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        data_nx  = data_q;
        keep_nx  = keep_q;
        last_nx  = last_q;
        pend_nx  = pend | bus.flush;
        done_nx  = 1'b0;
        case (state)
            FILL: begin
                if (pop) begin
                    data_nx[idx*FIFO_WIDTH +: FIFO_WIDTH] = bus.fifo_data;
                    keep_nx[idx] = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_nx   = '0;
                        state_nx = HOLD;
                        last_nx  = 1'b0;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else if (pend && bus.fifo_empty) begin
                    // Drained: close the partial word, or finish at once on a word boundary.
                    if (idx != '0) begin
                        idx_nx   = '0;
                        state_nx = HOLD;
                        last_nx  = 1'b1;
                    end else begin
                        pend_nx = 1'b0;
                        done_nx = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nx = FILL;
                    data_nx  = '0;
                    keep_nx  = '0;
                    last_nx  = 1'b0;
                    if (last_q) begin
                        pend_nx = 1'b0;
                        done_nx = 1'b1;
                    end
                end
            end
            default: state_nx = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    // NOTE: the word register is reset as well, since out_data/out_keep must read 0 after reset
    // and unfilled lanes of a partial word rely on starting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            idx    <= '0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            pend   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            data_q <= data_nx;
            keep_q <= keep_nx;
            last_q <= last_nx;
            pend   <= pend_nx;
            done_q <= done_nx;
        end
    end

    assign bus.fifo_read_en = pop;
    assign bus.out_valid    = (state == HOLD);
    assign bus.out_data     = data_q;
    assign bus.out_keep     = keep_q;
    assign bus.out_last     = last_q;
    assign bus.flush_done   = done_q;
    assign bus.busy         = (state == HOLD) | (idx != '0) | pend;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue models the FIFO, a byte-list model predicts every
// output word and flush completion, and a negedge monitor compares whatever the DUT presents.
module tb_fifo_rd_packer;
    localparam int W      = 8;
    localparam int P      = 4;
    localparam int WORD_W = W * P;

    typedef struct {
        bit                is_done;
        logic [WORD_W-1:0] data;
        logic [P-1:0]      keep;
        logic              last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         ready_mode = 0;
    bit         flush_out = 1'b0;
    exp_t       exp_q[$];
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] acc[$];
    int         accept_cyc[$];
    int         last_word_cyc = -10;
    int         done_cyc = -10;

    fifo_rd_packer_if #(.FIFO_WIDTH(W), .PACK(P)) bus ();

    fifo_rd_packer #(.FIFO_WIDTH(W), .PACK(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // FIFO model: show-ahead head entry, popped on read_en, sole driver of fifo_empty/fifo_data.
    always @(posedge clk) begin
        if (bus.fifo_read_en) begin
            check("read_when_empty", 64'(bus.fifo_empty), 64'd0);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        bus.fifo_empty <= (fifo_q.size() == 0);
        bus.fifo_data  <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    // Monitor: compares every accepted word and every flush_done pulse against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                check("word_expected", 64'(exp_q.size() != 0 && !exp_q[0].is_done), 64'd1);
                if (exp_q.size() != 0 && !exp_q[0].is_done) begin
                    e = exp_q.pop_front();
                    check("word_data", 64'(bus.out_data), 64'(e.data));
                    check("word_keep", 64'(bus.out_keep), 64'(e.keep));
                    check("word_last", 64'(bus.out_last), 64'(e.last));
                end
                accept_cyc.push_back(cyc);
                last_word_cyc = cyc;
            end
            if (bus.flush_done) begin
                check("done_expected", 64'(exp_q.size() != 0 && exp_q[0].is_done), 64'd1);
                if (exp_q.size() != 0 && exp_q[0].is_done) begin
                    void'(exp_q.pop_front());
                    flush_out = 1'b0;
                end
                done_cyc = cyc;
            end
        end
    end

    function automatic exp_t make_word(input logic last);
        exp_t e;
        e.is_done = 1'b0;
        e.data    = '0;
        e.keep    = '0;
        e.last    = last;
        foreach (acc[i]) begin
            e.data[i*W +: W] = acc[i];
            e.keep[i]        = 1'b1;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic push_byte(input logic [W-1:0] b);
        fifo_q.push_back(b);
        acc.push_back(b);
        if (acc.size() == P) begin
            exp_q.push_back(make_word(1'b0));
            acc.delete();
        end
    endtask

    // A new flush closes whatever bytes are outstanding; one raised while a flush is still
    // pending (its done pulse not yet visible) is absorbed and predicts nothing.
    task automatic flush_req();
        exp_t d;
        if (!flush_out) begin
            if (acc.size() != 0) exp_q.push_back(make_word(1'b1));
            acc.delete();
            d.is_done = 1'b1;
            d.data    = '0;
            d.keep    = '0;
            d.last    = 1'b0;
            exp_q.push_back(d);
            flush_out = 1'b1;
            bus.flush = 1'b1;
        end else if (!bus.flush_done) begin
            bus.flush = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || flush_out) && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size() == 0 && fifo_q.size() == 0 && !flush_out), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_data"},  64'(bus.out_data),  64'd0);
        check({tag, "_keep"},  64'(bus.out_keep),  64'd0);
        check({tag, "_last"},  64'(bus.out_last),  64'd0);
        check({tag, "_done"},  64'(bus.flush_done), 64'd0);
        check({tag, "_busy"},  64'(bus.busy),      64'd0);
        check({tag, "_rden"},  64'(bus.fifo_read_en), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;

        // Two full words back to back; one word per PACK+1 cycles.
        ready_mode = 1;
        tick();
        accept_cyc.delete();
        for (int i = 1; i <= 8; i++) push_byte(8'(i * 8'h11));
        wait_idle(60, "t1_idle");
        check("t1_words", 64'(accept_cyc.size()), 64'd2);
        if (accept_cyc.size() == 2)
            check("t1_rate", 64'(accept_cyc[1] - accept_cyc[0]), 64'(P + 1));

        // Consumer stalls: the first word must hold steady and no pops may happen.
        ready_mode = 0;
        tick();
        accept_cyc.delete();
        for (int i = 1; i <= 8; i++) push_byte(8'(i * 8'h11));
        n = 0;
        while (!bus.out_valid && n < 12) begin
            tick();
            n++;
        end
        check("t2_hold_reached", 64'(bus.out_valid), 64'd1);
        repeat (10) begin
            check("t2_stall_valid", 64'(bus.out_valid), 64'd1);
            check("t2_stall_data",  64'(bus.out_data), 64'h44332211);
            check("t2_stall_keep",  64'(bus.out_keep), 64'hF);
            check("t2_stall_rden",  64'(bus.fifo_read_en), 64'd0);
            tick();
        end
        ready_mode = 1;
        wait_idle(40, "t2_idle");
        check("t2_words", 64'(accept_cyc.size()), 64'd2);
        if (accept_cyc.size() == 2)
            check("t2_rate", 64'(accept_cyc[1] - accept_cyc[0]), 64'(P + 1));

        // Partial word closed by a flush; done pulses the cycle after acceptance.
        push_byte(8'hA1);
        push_byte(8'hA2);
        flush_req();
        tick();
        wait_idle(40, "t3_idle");
        check("t3_done_timing", 64'(done_cyc - last_word_cyc), 64'd1);

        // Flush on an empty FIFO at a word boundary: no word, done on the second cycle.
        flush_req();
        tick();
        check("t4_done_early", 64'(bus.flush_done), 64'd0);
        check("t4_valid_c1",   64'(bus.out_valid), 64'd0);
        tick();
        check("t4_done_pulse", 64'(bus.flush_done), 64'd1);
        check("t4_valid_c2",   64'(bus.out_valid), 64'd0);
        tick();
        check("t4_done_clear", 64'(bus.flush_done), 64'd0);
        check("t4_busy_clear", 64'(bus.busy), 64'd0);

        // Empty FIFO throughout, random flushes and ready.
        ready_mode = 2;
        repeat (200) begin
            if ($urandom_range(0, 7) == 0) flush_req();
            tick();
            check("t5_rden", 64'(bus.fifo_read_en), 64'd0);
            check("t5_valid", 64'(bus.out_valid), 64'd0);
        end
        wait_idle(20, "t5_idle");

        // Random traffic with random backpressure and flushes.
        repeat (1500) begin
            r = int'($urandom_range(0, 99));
            if (!flush_out && r < 45 && fifo_q.size() < 16) push_byte(8'($urandom));
            else if (r >= 97) flush_req();
            tick();
        end
        if (!flush_out) flush_req();
        tick();
        wait_idle(400, "t6_idle");

        // Reset in the middle of a word discards it; the next four bytes form a clean word.
        ready_mode = 0;
        tick();
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        repeat (6) tick();
        check("t7_busy_partial", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        acc.delete();
        push_byte(8'h01);
        tick();
        check_zero("t7_reset");
        rst = 1'b0;
        ready_mode = 1;
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        wait_idle(40, "t7_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
